// File: rtl/conv_v.sv
// conv_v: 3x3 convolution over a 5x5 binary image with an optional
// 9-tap dense stage. Conv mode streams one window result per cycle;
// dense mode accumulates S_A(k) * d_k over the nine windows and emits one
// result. All operands are captured when leaving IDLE, so inputs may
// change freely while an operation is running.
module conv_v #(
  parameter int SIZE = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               prov,
  input  logic [4:0]               matrix,
  input  logic [9:0]               matrix2,
  input  logic [9:0]               i,
  input  logic signed [SIZE-1:0]   w1,
  input  logic signed [SIZE-1:0]   w2,
  input  logic signed [SIZE-1:0]   w3,
  input  logic signed [SIZE-1:0]   w4,
  input  logic signed [SIZE-1:0]   w5,
  input  logic signed [SIZE-1:0]   w6,
  input  logic signed [SIZE-1:0]   w7,
  input  logic signed [SIZE-1:0]   w8,
  input  logic signed [SIZE-1:0]   w9,
  input  logic signed [SIZE-1:0]   w11,
  input  logic signed [SIZE-1:0]   w12,
  input  logic signed [SIZE-1:0]   w13,
  input  logic signed [SIZE-1:0]   w14,
  input  logic signed [SIZE-1:0]   w15,
  input  logic signed [SIZE-1:0]   w16,
  input  logic signed [SIZE-1:0]   w17,
  input  logic signed [SIZE-1:0]   w18,
  input  logic signed [SIZE-1:0]   w19,
  input  logic                     conv_en,
  input  logic                     dense_en,
  output logic signed [2*SIZE-2:0] Y1,
  output logic                     y_valid,
  output logic                     busy,
  output logic [3:0]               win_idx
);

  // Window sum width, dense accumulator width, result width
  localparam int SW = SIZE + 4;
  localparam int AW = 2*SIZE + 4;
  localparam int YW = 2*SIZE - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DENSE} state_t;

  state_t                 r_state;
  logic [1:0]             r_prov;
  logic [24:0]            r_img;
  logic signed [SIZE-1:0] r_wa [9];
  logic signed [SIZE-1:0] r_wb [9];
  logic [3:0]             r_k;
  logic signed [AW-1:0]   r_acc;

  logic signed [SIZE-1:0] w_in_a [9];
  logic signed [SIZE-1:0] w_in_b [9];
  logic [24:0]            w_pix;
  logic [4:0]             w_base;
  logic                   w_use_b;
  logic signed [SW-1:0]   w_term [9];
  logic signed [SW-1:0]   w_sum;
  logic signed [AW-1:0]   w_sum_x;
  logic signed [AW-1:0]   w_d_x;
  logic signed [AW-1:0]   w_prod;
  logic signed [AW-1:0]   w_acc_next;

  assign w_in_a[0] = w1;
  assign w_in_a[1] = w2;
  assign w_in_a[2] = w3;
  assign w_in_a[3] = w4;
  assign w_in_a[4] = w5;
  assign w_in_a[5] = w6;
  assign w_in_a[6] = w7;
  assign w_in_a[7] = w8;
  assign w_in_a[8] = w9;
  assign w_in_b[0] = w11;
  assign w_in_b[1] = w12;
  assign w_in_b[2] = w13;
  assign w_in_b[3] = w14;
  assign w_in_b[4] = w15;
  assign w_in_b[5] = w16;
  assign w_in_b[6] = w17;
  assign w_in_b[7] = w18;
  assign w_in_b[8] = w19;

  // Reorder the image so that w_pix[5r+c] is pixel p[r][c]
  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_pix
      assign w_pix[gi] = r_img[24-gi];
    end
  endgenerate

  // Top-left pixel index of window k = 3a+b is 5a+b
  always_comb begin
    w_base = 5'd0;
    case (r_k)
      4'd0: w_base = 5'd0;
      4'd1: w_base = 5'd1;
      4'd2: w_base = 5'd2;
      4'd3: w_base = 5'd5;
      4'd4: w_base = 5'd6;
      4'd5: w_base = 5'd7;
      4'd6: w_base = 5'd10;
      4'd7: w_base = 5'd11;
      4'd8: w_base = 5'd12;
      default: w_base = 5'd0;
    endcase
  end

  // Kernel B is only ever used for convolution; dense always convolves with A
  assign w_use_b = (r_state == ST_CONV) && r_prov[0];

  // One tap per kernel element: pixel 1 passes the weight, pixel 0 gives
  // zero (binary coding) or the negated weight (bipolar coding)
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam logic [4:0] OFF = 5'((gi / 3) * 5 + (gi % 3));
      logic signed [SIZE-1:0] w_coef;
      logic signed [SW-1:0]   w_ext;
      logic                   w_p;
      assign w_coef    = w_use_b ? r_wb[gi] : r_wa[gi];
      assign w_ext     = {{4{w_coef[SIZE-1]}}, w_coef};
      assign w_p       = w_pix[w_base + OFF];
      assign w_term[gi] = w_p ? w_ext : (r_prov[1] ? '0 : -w_ext);
    end
  endgenerate

  // Sum the nine taps of the current window
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < 9; t++) begin
      w_sum = w_sum + w_term[t];
    end
  end

  assign w_sum_x    = {{(AW-SW){w_sum[SW-1]}}, w_sum};
  assign w_d_x      = {{(AW-SIZE){r_wb[r_k][SIZE-1]}}, r_wb[r_k]};
  assign w_prod     = w_sum_x * w_d_x;
  assign w_acc_next = r_acc + w_prod;

  // Control FSM with operand capture, dense accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prov  <= '0;
      r_img   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      for (int t = 0; t < 9; t++) begin
        r_wa[t] <= '0;
        r_wb[t] <= '0;
      end
      Y1      <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      win_idx <= '0;
    end else begin
      y_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (conv_en || dense_en) begin
            r_state <= conv_en ? ST_CONV : ST_DENSE;
            r_prov  <= prov;
            r_img   <= {matrix, matrix2, i};
            for (int t = 0; t < 9; t++) begin
              r_wa[t] <= w_in_a[t];
              r_wb[t] <= w_in_b[t];
            end
            r_k     <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CONV: begin
          Y1      <= {{(YW-SW){w_sum[SW-1]}}, w_sum};
          win_idx <= r_k;
          y_valid <= 1'b1;
          if (r_k == 4'd8) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        ST_DENSE: begin
          r_acc <= w_acc_next;
          if (r_k == 4'd8) begin
            Y1      <= w_acc_next[YW-1:0];
            y_valid <= 1'b1;
            win_idx <= 4'd8;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_v.sv
// Directed bench for conv_v: hand-computed window sums for the reference
// image under both kernels and both pixel codings, dense result, priority,
// re-trigger, operand capture and reset abort.
module tb_conv_v;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         prov;
  logic [4:0]         matrix;
  logic [9:0]         matrix2;
  logic [9:0]         i;
  logic signed [22:0] ka [9];
  logic signed [22:0] kb [9];
  logic               conv_en;
  logic               dense_en;
  logic signed [44:0] Y1;
  logic               y_valid;
  logic               busy;
  logic [3:0]         win_idx;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_a [9] = '{5, 2, 3, 3, 4, 3, 4, 3, 4};
  int exp_b [9] = '{5, 0, 4, 2, 4, 2, 4, 2, 3};

  conv_v #(.SIZE(23)) dut (
    .clk(clk), .rst_n(rst_n), .prov(prov),
    .matrix(matrix), .matrix2(matrix2), .i(i),
    .w1(ka[0]), .w2(ka[1]), .w3(ka[2]), .w4(ka[3]), .w5(ka[4]),
    .w6(ka[5]), .w7(ka[6]), .w8(ka[7]), .w9(ka[8]),
    .w11(kb[0]), .w12(kb[1]), .w13(kb[2]), .w14(kb[3]), .w15(kb[4]),
    .w16(kb[5]), .w17(kb[6]), .w18(kb[7]), .w19(kb[8]),
    .conv_en(conv_en), .dense_en(dense_en),
    .Y1(Y1), .y_valid(y_valid), .busy(busy), .win_idx(win_idx)
  );

  always #5 clk = ~clk;

  // 45-bit two's-complement image of an integer expectation
  function automatic logic [44:0] ev(input int v);
    longint lv;
    lv = v;
    return lv[44:0];
  endfunction

  task automatic chk(input string tag, input logic [44:0] obs, input logic [44:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ref();
    matrix  = 5'b10101;
    matrix2 = 10'b1101110100;
    i       = 10'b0011011100;
    ka = '{23'sd1, 23'sd0, 23'sd0, 23'sd1, 23'sd1, 23'sd0, 23'sd1, 23'sd1, 23'sd1};
    kb = '{23'sd1, 23'sd0, 23'sd1, 23'sd0, 23'sd1, 23'sd0, 23'sd1, 23'sd0, 23'sd1};
  endtask

  // Start edge of a conv sweep with a one-cycle enable pulse
  task automatic start_conv(input logic [1:0] p);
    prov    = p;
    conv_en = 1'b1;
    tick();
    conv_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    conv_en  = 1'b1;
    dense_en = 1'b0;
    prov     = 2'b10;
    load_ref();

    // Reset held with conv_en high
    tick();
    tick();
    chk("rst_y1", Y1, ev(0));
    chk("rst_valid", 45'(y_valid), ev(0));
    chk("rst_busy", 45'(busy), ev(0));
    chk("rst_win", 45'(win_idx), ev(0));

    // Release reset with conv_en still high: next edge starts the sweep
    rst_n = 1'b1;
    tick();
    conv_en = 1'b0;
    chk("start_busy", 45'(busy), ev(1));
    chk("start_valid", 45'(y_valid), ev(0));
    for (int k = 0; k < 9; k++) begin
      tick();
      $display("binA k=%0d Y1=%0d win=%0d valid=%0b", k, Y1, win_idx, y_valid);
      chk($sformatf("binA_y1_%0d", k), Y1, ev(exp_a[k]));
      chk($sformatf("binA_win_%0d", k), 45'(win_idx), ev(k));
      chk($sformatf("binA_valid_%0d", k), 45'(y_valid), ev(1));
    end
    chk("binA_end_busy", 45'(busy), ev(0));
    tick();
    chk("idle_valid", 45'(y_valid), ev(0));
    chk("idle_hold_y1", Y1, ev(4));

    // Binary coding, kernel B
    start_conv(2'b11);
    for (int k = 0; k < 9; k++) begin
      tick();
      $display("binB k=%0d Y1=%0d win=%0d valid=%0b", k, Y1, win_idx, y_valid);
      chk($sformatf("binB_y1_%0d", k), Y1, ev(exp_b[k]));
      chk($sformatf("binB_valid_%0d", k), 45'(y_valid), ev(1));
    end
    tick();

    // Bipolar coding, kernel A: first window
    start_conv(2'b00);
    tick();
    $display("bipA k=0 Y1=%0d", Y1);
    chk("bipA_y1_0", Y1, ev(4));
    repeat (9) tick();

    // Bipolar coding, kernel B: second window is -5
    start_conv(2'b01);
    tick();
    tick();
    $display("bipB k=1 Y1=%0d win=%0d", Y1, win_idx);
    chk("bipB_win_1", 45'(win_idx), ev(1));
    chk("bipB_y1_1", Y1, ev(-5));
    repeat (8) tick();

    // Dense: a single result 9 cycles after the start edge
    prov     = 2'b10;
    dense_en = 1'b1;
    tick();
    dense_en = 1'b0;
    chk("dense_busy", 45'(busy), ev(1));
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c < 9) chk($sformatf("dense_quiet_%0d", c), 45'(y_valid), ev(0));
    end
    $display("dense Y1=%0d win=%0d valid=%0b", Y1, win_idx, y_valid);
    chk("dense_valid", 45'(y_valid), ev(1));
    chk("dense_y1", Y1, ev(20));
    chk("dense_win", 45'(win_idx), ev(8));
    tick();
    chk("dense_after_valid", 45'(y_valid), ev(0));

    // Both enables high: conv wins
    prov     = 2'b10;
    conv_en  = 1'b1;
    dense_en = 1'b1;
    tick();
    conv_en  = 1'b0;
    dense_en = 1'b0;
    tick();
    $display("prio Y1=%0d win=%0d valid=%0b", Y1, win_idx, y_valid);
    chk("prio_valid", 45'(y_valid), ev(1));
    chk("prio_y1", Y1, ev(5));
    repeat (9) tick();

    // Negative weight: w1 = -1, others zero
    ka = '{-23'sd1, 23'sd0, 23'sd0, 23'sd0, 23'sd0, 23'sd0, 23'sd0, 23'sd0, 23'sd0};
    start_conv(2'b10);
    tick();
    $display("neg Y1=%0d", Y1);
    chk("neg_y1", Y1, ev(-1));
    repeat (9) tick();
    load_ref();

    // Input changes mid-sweep are ignored
    start_conv(2'b10);
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 2) begin
        matrix  = 5'b0;
        matrix2 = 10'b0;
        i       = 10'b0;
        prov    = 2'b01;
        ka = '{9{23'sd7}};
        kb = '{9{-23'sd3}};
      end
      if (k >= 3) begin
        $display("hold k=%0d Y1=%0d", k, Y1);
        chk($sformatf("hold_y1_%0d", k), Y1, ev(exp_a[k]));
      end
    end
    tick();
    load_ref();

    // Enable held across the end of a sweep: one IDLE cycle, then restart
    prov    = 2'b10;
    conv_en = 1'b1;
    tick();
    repeat (9) tick();
    chk("retrig_last_valid", 45'(y_valid), ev(1));
    tick();
    chk("retrig_gap_valid", 45'(y_valid), ev(0));
    chk("retrig_gap_busy", 45'(busy), ev(1));
    conv_en = 1'b0;
    tick();
    $display("retrig Y1=%0d win=%0d valid=%0b", Y1, win_idx, y_valid);
    chk("retrig_y1", Y1, ev(5));
    chk("retrig_win", 45'(win_idx), ev(0));

    // Reset mid-sweep aborts
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    $display("abort Y1=%0d valid=%0b busy=%0b", Y1, y_valid, busy);
    chk("abort_valid", 45'(y_valid), ev(0));
    chk("abort_busy", 45'(busy), ev(0));
    chk("abort_y1", Y1, ev(0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_idle_busy", 45'(busy), ev(0));
    chk("abort_idle_valid", 45'(y_valid), ev(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_v.md
Name: conv_v

Overview:
- Binary-image 3x3 convolution engine with an optional 9-input dense (dot-product) stage.
- The 5x5 binary image is formed from matrix, matrix2 and i.
- Two 3x3 signed kernels are provided: w1..w9 (kernel A) and w11..w19 (kernel B).
- Sits between the image/weight registers and the classifier; Y1 streams per-window convolution results or one dense result.

Parameters:
SIZE, 23, signed weight width; Y1 width is 2*SIZE-1.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
prov  input  2  mode: bit1 = pixel coding (1 = {0,1}, 0 = {-1,+1}); bit0 = conv kernel select (0 = A, 1 = B)
matrix  input  5  image row 0
matrix2  input  10  image rows 1-2
i  input  10  image rows 3-4
w1..w9  input  SIZE each  kernel A, signed, row-major (w1 = k[0][0], w9 = k[2][2])
w11..w19  input  SIZE each  kernel B, signed, row-major; also the dense weights d0..d8
conv_en  input  1  start convolution sweep
dense_en  input  1  start dense evaluation
Y1  output  2*SIZE-1  signed result, registered
y_valid  output  1  one-cycle-per-result strobe
busy  output  1  high while not IDLE
win_idx  output  4  window index 0..8 of current Y1 (conv mode); 8 for dense result

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; Y1=0, y_valid=0, busy=0, win_idx=0. Reset overrides any operation in progress and aborts it.
- Image mapping:
  - img = {matrix, matrix2, i} (25 bits).
  - Pixel p[r][c] = img[24-5r-c], for r,c in 0..4.
  - Pixel value x = p when prov[1]=1; x = 2p-1 when prov[1]=0.
- Window k = 3a+b, with a,b in 0..2.
- Window sum: S(k) = sum over u,v of K[u][v] * x(p[a+u][b+v]).
  - Pixel products are gating/negation only; no multipliers are needed for the conv stage.
  - Compute at SIZE+4 bits signed, then sign-extend to Y1 width.
- FSM states: IDLE, CONV, DENSE.
  - IDLE:
    - conv_en=1 → CONV.
    - else dense_en=1 → DENSE.
    - If both are high, conv has priority.
  - Start latch: on leaving IDLE, latch prov, img and all 18 weights. Input changes during an operation are ignored.
- CONV: 9 cycles, k = 0..8.
  - Each cycle: Y1 <= S(k) using the kernel selected by the latched prov[0]; win_idx <= k; y_valid <= 1.
  - After k=8 → IDLE.
  - First result is registered on the edge after the start edge. Latency 1, throughput 1 window/cycle.
- DENSE: 9 cycles, k = 0..8.
  - Conv kernel is always A; latched prov[1] still selects pixel coding; prov[0] is ignored.
  - Each cycle: acc += S_A(k) * d_k, with d_k = w1(k+1), i.e. d0 = w11 … d8 = w19.
  - Accumulator width 2*SIZE+4 signed.
  - On k=8: Y1 <= low 2*SIZE-1 bits of the final acc (two's-complement wrap, no saturation); y_valid <= 1 for that single cycle; win_idx <= 8; → IDLE.
  - acc clears at DENSE entry.
- Outputs and re-trigger:
  - y_valid is 0 whenever no new result is written.
  - Y1 holds its last value in IDLE.
  - busy = 1 in CONV/DENSE.
  - An enable still high when returning to IDLE re-triggers a new operation on the next edge; there is one IDLE cycle between operations.
  - Enables are level-sensitive in IDLE only.

Test Plan:
- Common setup: matrix=10101, matrix2=1101110100, i=0011011100. Kernel A = w1..w9 = 1,0,0,1,1,0,1,1,1. Kernel B = w11..w19 = 1,0,1,0,1,0,1,0,1.
- Reset: rst_n=0 for 2 cycles with conv_en=1 → Y1=0, y_valid=0, busy=0. Deassert reset → CONV starts on the next edge.
- Binary conv, kernel A: prov=10, conv_en pulse → Y1 sequence 5,2,3,3,4,3,4,3,4 on 9 consecutive y_valid cycles, win_idx 0..8.
- Binary conv, kernel B: prov=11 → Y1 sequence 5,0,4,2,4,2,4,2,3.
- Bipolar conv: prov=00 → first Y1=4 (kernel A). prov=01 → second Y1=-5, i.e. all 45 bits of 2's-complement -5.
- Dense: prov=10, dense_en pulse → exactly one y_valid, 9 cycles after the start edge, with Y1=20.
- Sign and abort cases:
  - w1 = all ones (-1), w2..w9 = 0, prov=10 → first Y1 = -1 (45 ones).
  - Change inputs mid-sweep → no effect on the remaining results.
  - rst_n=0 mid-sweep → y_valid drops and the state returns to IDLE.
